// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// control states, iteration count and the divide-by-zero quotient.
package mdu_pkg;

  localparam int MDU_ITERS = 32;
  localparam logic [31:0] MDU_DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // Magnitude of a value that is two's complement only when is_signed is set.
  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dividend_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;

  assign w_shifted = {i_rem, i_dividend_bit};
  // The true difference is below 2^WIDTH whenever the divisor fits.
  assign w_diff    = w_shifted[WIDTH-1:0] - i_divisor;
  assign o_qbit    = (w_shifted >= {1'b0, i_divisor});
  assign o_rem     = o_qbit ? w_diff : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Optional: define MDU_EARLY_TERM_EN to let multiplies stop once the
// remaining multiplier bits are all zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mdu_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_write,
  input  logic             i_lo_write,
  input  logic [WIDTH-1:0] i_write_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(MDU_ITERS);

  mdu_state_e r_state, w_state_next;

  logic [CNT_W-1:0]   r_count;
  logic               r_is_div;
  logic               r_neg_prod;
  logic               r_neg_quo;
  logic               r_neg_rem;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_a_raw;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  mdu_op_e            w_op;
  logic               w_op_div;
  logic               w_op_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_mplier_shift;
  logic               w_step_last;
  logic               w_mult_early;
  logic               w_run_done;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_op        = mdu_op_e'(i_mdu_op);
  assign w_op_div    = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
  assign w_op_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
  assign w_mag_a     = mdu_abs(i_a, w_op_signed);
  assign w_mag_b     = mdu_abs(i_b, w_op_signed);

  assign w_mplier_shift = r_mplier >> 1;
  assign w_step_last    = (r_count == CNT_W'(MDU_ITERS - 1));

`ifdef MDU_EARLY_TERM_EN
  assign w_mult_early = !r_is_div && (w_mplier_shift == '0);
`else
  assign w_mult_early = 1'b0;
`endif

  assign w_run_done = w_step_last || w_mult_early;

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem          (r_rem),
    .i_dividend_bit (r_quo[WIDTH-1]),
    .i_divisor      (r_mplier),
    .o_rem          (w_rem_next),
    .o_qbit         (w_qbit)
  );

  // Magnitudes were computed on |A| and |B|; restore signs for the final write.
  assign w_prod = r_neg_prod ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_neg_quo  ? (~r_quo + 1'b1) : r_quo;
  assign w_rem  = r_neg_rem  ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = RUN;
      RUN:     if (w_run_done) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_prod <= 1'b0;
      r_neg_quo  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_b_zero   <= 1'b0;
      r_a_raw    <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_count    <= '0;
            r_dbz      <= 1'b0;
            r_is_div   <= w_op_div;
            r_neg_prod <= w_op_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_quo  <= w_op_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_rem  <= w_op_signed && i_a[WIDTH-1];
            r_b_zero   <= (i_b == '0);
            r_a_raw    <= i_a;
            r_acc      <= '0;
            r_mcand    <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier   <= w_mag_b;
            r_rem      <= '0;
            r_quo      <= w_mag_a;
          end else begin
            if (i_hi_write) r_hi <= i_write_data;
            if (i_lo_write) r_lo <= i_write_data;
          end
        end
        RUN: begin
          r_count <= r_count + 1'b1;
          if (r_is_div) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shift;
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (!r_is_div) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_b_zero) begin
            r_hi  <= r_a_raw;
            r_lo  <= MDU_DIV0_QUOT;
            r_dbz <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule
